// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial-in and parallel-out bundle between a bit source/sink and the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic             clr;
    logic             sin;
    logic             sin_valid;
    logic             pout_ready;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    modport master (
        output clr, sin, sin_valid, pout_ready,
        input  pout, pout_valid, bit_cnt, overrun
    );
    modport slave (
        input  clr, sin, sin_valid, pout_ready,
        output pout, pout_valid, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: double-buffered serial-to-parallel converter with an EMPTY/FULL holding register and sticky overrun.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    sipo_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_ovr;
    logic [WIDTH-1:0] w_next;
    logic             w_done;
    logic [0:0]       w_state_nxt;

    always_comb begin
        w_next      = MSB_FIRST ? {r_shift[WIDTH-2:0], bus.sin} : {bus.sin, r_shift[WIDTH-1:1]};
        w_done      = !bus.clr && bus.sin_valid && (r_cnt == CW'(WIDTH - 1));
        w_state_nxt = w_done ? FULL : (r_state == FULL && bus.pout_ready) ? EMPTY : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= EMPTY;
            r_hold  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (bus.clr) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (bus.sin_valid) begin
                r_shift <= w_next;
                r_cnt   <= w_done ? '0 : r_cnt + 1'b1;
            end
            // a completed word is only dropped when the holding register is full and not being drained
            if (bus.clr)
                r_ovr <= 1'b0;
            else if (w_done && r_state == FULL && !bus.pout_ready)
                r_ovr <= 1'b1;
            if (w_done && (r_state == EMPTY || bus.pout_ready))
                r_hold <= w_next;
            r_state <= w_state_nxt;
        end
    end

    assign bus.pout       = r_hold;
    assign bus.pout_valid = (r_state == FULL);
    assign bus.bit_cnt    = r_cnt;
    assign bus.overrun    = r_ovr;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: drives MSB-first and LSB-first instances with shared stimulus against a bit-list reference model.
module tb_sipo_deserializer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    logic t_clr, t_sin, t_sin_valid, t_ready;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(W)) bm ();
    sipo_deserializer_if #(.WIDTH(W)) bl ();

    assign bm.clr = t_clr;
    assign bm.sin = t_sin;
    assign bm.sin_valid = t_sin_valid;
    assign bm.pout_ready = t_ready;
    assign bl.clr = t_clr;
    assign bl.sin = t_sin;
    assign bl.sin_valid = t_sin_valid;
    assign bl.pout_ready = t_ready;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm.slave));
    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl.slave));

    // reference: bits received so far in arrival order, plus the word currently held
    int           m_cnt;
    bit           m_bits [W];
    logic [W-1:0] m_msb, m_lsb;
    bit           m_valid, m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, c, v, s, rdy);
        bit           done;
        logic [W-1:0] wm, wl;
        done = 0;
        if (r) begin
            m_cnt = 0; m_valid = 0; m_ovr = 0; m_msb = '0; m_lsb = '0;
            return;
        end
        if (c) begin
            m_cnt = 0; m_ovr = 0;
        end else if (v) begin
            m_bits[m_cnt] = s;
            m_cnt++;
            if (m_cnt == W) begin
                done = 1; m_cnt = 0;
            end
        end
        for (int i = 0; i < W; i++) begin
            wm[W-1-i] = m_bits[i];
            wl[i]     = m_bits[i];
        end
        if (!m_valid) begin
            if (done) begin
                m_valid = 1; m_msb = wm; m_lsb = wl;
            end
        end else if (done) begin
            if (rdy) begin
                m_msb = wm; m_lsb = wl;
            end else
                m_ovr = 1;
        end else if (rdy)
            m_valid = 0;
    endtask

    task automatic step(input bit r, c, v, s, rdy);
        rst = r; t_clr = c; t_sin_valid = v; t_sin = s; t_ready = rdy;
        @(posedge clk);
        model_update(r, c, v, s, rdy);
        #1;
        check("msb_pout", 32'(bm.pout), 32'(m_msb));
        check("lsb_pout", 32'(bl.pout), 32'(m_lsb));
        check("msb_valid", 32'(bm.pout_valid), 32'(m_valid));
        check("lsb_valid", 32'(bl.pout_valid), 32'(m_valid));
        check("msb_cnt", 32'(bm.bit_cnt), 32'(m_cnt));
        check("lsb_cnt", 32'(bl.bit_cnt), 32'(m_cnt));
        check("msb_ovr", 32'(bm.overrun), 32'(m_ovr));
        check("lsb_ovr", 32'(bl.overrun), 32'(m_ovr));
    endtask

    task automatic send(input logic [W-1:0] bits, input bit rdy);
        for (int i = W - 1; i >= 0; i--) step(0, 0, 1, bits[i], rdy);
    endtask

    initial begin
        logic [W-1:0] b;
        m_cnt = 0; m_valid = 0; m_ovr = 0; m_msb = '0; m_lsb = '0;
        step(1, 0, 1, 1, 1);
        check("rst_pout", 32'(bm.pout), 32'h0);
        check("rst_valid", 32'(bm.pout_valid), 32'h0);
        check("rst_cnt", 32'(bm.bit_cnt), 32'h0);
        check("rst_ovr", 32'(bm.overrun), 32'h0);
        b = 4'b1011;
        send(b, 1);
        check("w1_msb", 32'(bm.pout), 32'hB);
        check("w1_lsb", 32'(bl.pout), 32'hD);
        check("w1_valid", 32'(bm.pout_valid), 32'h1);
        step(0, 0, 0, 0, 1);
        check("w1_drop", 32'(bm.pout_valid), 32'h0);
        check("w1_keep", 32'(bm.pout), 32'hB);
        b = 4'b1011;
        send(b, 0);
        b = 4'b0110;
        send(b, 0);
        check("ovr_pout", 32'(bm.pout), 32'hB);
        check("ovr_set", 32'(bm.overrun), 32'h1);
        step(0, 0, 0, 0, 1);
        check("ovr_drain", 32'(bm.pout_valid), 32'h0);
        step(0, 1, 0, 0, 0);
        check("clr_ovr", 32'(bm.overrun), 32'h0);
        b = 4'b1100;
        send(b, 0);
        check("bb_w1", 32'(bm.pout), 32'hC);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        check("bb_w2", 32'(bm.pout), 32'h3);
        check("bb_valid", 32'(bm.pout_valid), 32'h1);
        check("bb_ovr", 32'(bm.overrun), 32'h0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        check("mid_cnt", 32'(bm.bit_cnt), 32'h2);
        step(1, 0, 0, 0, 0);
        check("mid_rst", 32'(bm.bit_cnt), 32'h0);
        b = 4'b0101;
        send(b, 0);
        check("rst_word", 32'(bm.pout), 32'h5);
        step(0, 0, 0, 0, 1);
        b = 4'b1011;
        for (int i = W - 1; i >= 0; i--) begin
            step(0, 0, 1, b[i], 0);
            if (i != 0) step(0, 0, 0, 1, 0);
        end
        check("gap_word", 32'(bm.pout), 32'hB);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        check("clr_cnt", 32'(bm.bit_cnt), 32'h0);
        check("clr_hold", 32'(bm.pout), 32'hB);
        check("clr_valid", 32'(bm.pout_valid), 32'h1);
        for (int k = 0; k < 800; k++) begin
            bit r, c;
            r = ($urandom_range(0, 63) == 0);
            c = ($urandom_range(0, 31) == 0);
            step(r, c, $urandom_range(0, 9) < 7, 1'($urandom), c ? 1'b0 : 1'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
